// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the CPU fetch port and data port.
// Data goes first, then fetch; results are buffered and presented in DONE.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_wdata_i,
    output logic [31:0] ram_rdata_o,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);
    typedef enum logic [2:0] {S_IDLE, S_DATA, S_INST, S_DONE, S_DRAIN} state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;

    // Abort on the edge that would complete TIMEOUT_CYCLES waiting cycles.
    assign w_timeout  = !bus_ack_i && (r_cnt == LP_LAST);
    assign stallreq_o = (r_state == S_DRAIN) ||
                        ((r_state != S_DONE) && (rom_ce_i || ram_ce_i));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_err_o   <= 1'b0;
            rom_data_o  <= '0;
            ram_rdata_o <= '0;
        end else begin
            bus_err_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (ram_ce_i) begin
                        r_state     <= S_DATA;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= ram_we_i;
                        bus_sel_o   <= ram_sel_i;
                        bus_addr_o  <= ram_addr_i;
                        bus_wdata_o <= ram_we_i ? ram_wdata_i : '0;
                    end else if (rom_ce_i) begin
                        r_state     <= S_INST;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'hF;
                        bus_addr_o  <= rom_addr_i;
                        bus_wdata_o <= '0;
                    end
                end
                S_DATA, S_INST: begin
                    if (bus_ack_i) begin
                        r_cnt <= '0;
                        if (!flush_i && r_state == S_DATA && !bus_we_o)
                            ram_rdata_o <= bus_rdata_i;
                        if (!flush_i && r_state == S_INST)
                            rom_data_o <= bus_rdata_i;
                        if (flush_i) begin
                            r_state   <= S_IDLE;
                            bus_req_o <= 1'b0;
                        end else if (r_state == S_DATA && rom_ce_i) begin
                            // Back-to-back fetch: bus_req_o stays high.
                            r_state     <= S_INST;
                            bus_we_o    <= 1'b0;
                            bus_sel_o   <= 4'hF;
                            bus_addr_o  <= rom_addr_i;
                            bus_wdata_o <= '0;
                        end else begin
                            r_state   <= S_DONE;
                            bus_req_o <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_cnt     <= '0;
                        r_state   <= S_DONE;
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        if (r_state == S_DATA) ram_rdata_o <= '0;
                        else                   rom_data_o  <= '0;
                    end else if (flush_i) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // The access cannot be withdrawn; wait it out and drop the result.
                    if (bus_ack_i) begin
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                        bus_req_o <= 1'b0;
                    end else if (w_timeout) begin
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a memory model acks queued bus accesses and
// checks every requesting cycle against the expected-access queue.
module tb_mem_bus_arbiter;
    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk, rst;
    logic        rom_ce_i, ram_ce_i, ram_we_i, flush_i, bus_ack_i;
    logic [31:0] rom_addr_i, ram_addr_i, ram_wdata_i, bus_rdata_i;
    logic [3:0]  ram_sel_i;
    logic [31:0] rom_data_o, ram_rdata_o, bus_addr_o, bus_wdata_o;
    logic        stallreq_o, bus_req_o, bus_we_o, bus_err_o;
    logic [3:0]  bus_sel_o;

    bus_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          total = 0;
    int          bad = 0;
    int          wcnt = 0;
    int          mem_wait = 0;
    bit          mem_never = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
        .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
        .ram_addr_i(ram_addr_i), .ram_wdata_i(ram_wdata_i), .ram_rdata_o(ram_rdata_o),
        .flush_i(flush_i), .stallreq_o(stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: memory model + scoreboard at negedge, return at posedge+1.
    task automatic tick();
        bus_t e;
        @(negedge clk);
        bus_ack_i = 1'b0;
        if (bus_req_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL sb_unexpected: got access addr=%h, want none", bus_addr_o);
            end else begin
                e = exp_q[0];
                if ({bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o} !== e) begin
                    bad++;
                    $display("FAIL sb_bus: got we=%b sel=%h addr=%h wdata=%h, want we=%b sel=%h addr=%h wdata=%h",
                             bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, e.we, e.sel, e.addr, e.wdata);
                end
                if (!mem_never && wcnt >= mem_wait) begin
                    bus_ack_i = 1'b1;
                    bus_rdata_i = 32'h0;
                    if (rd_q.size() > 0) bus_rdata_i = rd_q.pop_front();
                    void'(exp_q.pop_front());
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end else begin
            wcnt = 0;
        end
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        total++; if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o} !== '0) begin
            bad++; $display("FAIL reset_bus: got req=%b we=%b sel=%h addr=%h wdata=%h err=%b, want all 0",
                            bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o); end
        total++; if ({rom_data_o, ram_rdata_o} !== 64'h0) begin
            bad++; $display("FAIL reset_bufs: got rom=%h ram=%h, want 0", rom_data_o, ram_rdata_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got stall=%b req=%b, want 0 0", stallreq_o, bus_req_o); end
    endtask

    task automatic test_fetch();
        mem_wait = 0;
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h100, wdata: 32'h0});
        rd_q.push_back(32'h3C010001);
        rom_ce_i = 1'b1; rom_addr_i = 32'h100; #1;
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL fetch_stall_idle: got %b want 1", stallreq_o); end
        tick();
        total++; if (bus_req_o !== 1'b1 || stallreq_o !== 1'b1) begin
            bad++; $display("FAIL fetch_inst: got req=%b stall=%b, want 1 1", bus_req_o, stallreq_o); end
        tick();
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
            bad++; $display("FAIL fetch_done: got req=%b stall=%b, want 0 0", bus_req_o, stallreq_o); end
        total++; if (rom_data_o !== 32'h3C010001) begin
            bad++; $display("FAIL fetch_data: got %h want 3c010001", rom_data_o); end
        rom_ce_i = 1'b0;
        tick();
        total++; if (bus_req_o !== 1'b0 || exp_q.size() != 0) begin
            bad++; $display("FAIL fetch_end: got req=%b pending=%0d, want 0 0", bus_req_o, exp_q.size()); end
    endtask

    task automatic test_load_fetch();
        mem_wait = 0;
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h2000, wdata: 32'h0});
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h104, wdata: 32'h0});
        rd_q.push_back(32'hDEADBEEF);
        rd_q.push_back(32'h00000000);
        ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_addr_i = 32'h2000; ram_wdata_i = 32'hFFFFFFFF;
        rom_ce_i = 1'b1; rom_addr_i = 32'h104;
        tick();
        total++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h2000) begin
            bad++; $display("FAIL lf_data_first: got req=%b addr=%h, want 1 00002000", bus_req_o, bus_addr_o); end
        tick();
        total++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h104 || stallreq_o !== 1'b1) begin
            bad++; $display("FAIL lf_b2b: got req=%b addr=%h stall=%b, want 1 00000104 1", bus_req_o, bus_addr_o, stallreq_o); end
        tick();
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
            bad++; $display("FAIL lf_done: got req=%b stall=%b, want 0 0", bus_req_o, stallreq_o); end
        total++; if (ram_rdata_o !== 32'hDEADBEEF || rom_data_o !== 32'h0) begin
            bad++; $display("FAIL lf_data: got ram=%h rom=%h, want deadbeef 00000000", ram_rdata_o, rom_data_o); end
        tick();
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b1) begin
            bad++; $display("FAIL lf_no_accept_in_done: got req=%b stall=%b, want 0 1", bus_req_o, stallreq_o); end
        ram_ce_i = 1'b0; rom_ce_i = 1'b0; #1;
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL lf_norq: got stall=%b want 0", stallreq_o); end
        tick();
    endtask

    task automatic test_store_wait();
        mem_wait = 5;
        exp_q.push_back('{we: 1'b1, sel: 4'h3, addr: 32'h3000, wdata: 32'h1234});
        rd_q.push_back(32'hCAFEF00D);
        ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_sel_i = 4'h3; ram_addr_i = 32'h3000; ram_wdata_i = 32'h1234;
        tick();
        for (int i = 0; i < 6; i++) begin
            total++; if (bus_req_o !== 1'b1 || stallreq_o !== 1'b1) begin
                bad++; $display("FAIL st_wait%0d: got req=%b stall=%b, want 1 1", i, bus_req_o, stallreq_o); end
            tick();
        end
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || ram_rdata_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL st_done: got req=%b stall=%b ram=%h, want 0 0 deadbeef", bus_req_o, stallreq_o, ram_rdata_o); end
        ram_ce_i = 1'b0; ram_we_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        rom_ce_i = 1'b1; rom_addr_i = 32'h200; flush_i = 1'b1;
        tick();
        total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL fl_idle: got req=%b want 0", bus_req_o); end
        flush_i = 1'b0; mem_wait = 3;
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h200, wdata: 32'h0});
        rd_q.push_back(32'h55AA55AA);
        tick();
        tick();
        flush_i = 1'b1; rom_ce_i = 1'b0;
        tick();
        flush_i = 1'b0; #1;
        total++; if (bus_req_o !== 1'b1 || stallreq_o !== 1'b1 || bus_addr_o !== 32'h200) begin
            bad++; $display("FAIL fl_drain: got req=%b stall=%b addr=%h, want 1 1 00000200", bus_req_o, stallreq_o, bus_addr_o); end
        tick();
        total++; if (bus_req_o !== 1'b1 || rom_data_o !== 32'h0) begin
            bad++; $display("FAIL fl_drain_hold: got req=%b rom=%h, want 1 00000000", bus_req_o, rom_data_o); end
        tick();
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || rom_data_o !== 32'h0 || exp_q.size() != 0) begin
            bad++; $display("FAIL fl_end: got req=%b stall=%b rom=%h pending=%0d, want 0 0 00000000 0",
                            bus_req_o, stallreq_o, rom_data_o, exp_q.size()); end
        // Flush in the same cycle as the ack: complete, discard, straight to IDLE.
        mem_wait = 1;
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h2100, wdata: 32'h0});
        rd_q.push_back(32'h77777777);
        ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_addr_i = 32'h2100;
        tick();
        tick();
        flush_i = 1'b1; ram_ce_i = 1'b0;
        tick();
        flush_i = 1'b0; #1;
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || ram_rdata_o !== 32'hDEADBEEF) begin
            bad++; $display("FAIL fl_ack_same: got req=%b stall=%b ram=%h, want 0 0 deadbeef", bus_req_o, stallreq_o, ram_rdata_o); end
    endtask

    task automatic test_timeout();
        mem_never = 1'b1;
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h4000, wdata: 32'h0});
        ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_addr_i = 32'h4000;
        rom_ce_i = 1'b1; rom_addr_i = 32'h500;
        tick();
        for (int i = 0; i < 8; i++) begin
            total++; if (bus_req_o !== 1'b1 || bus_err_o !== 1'b0) begin
                bad++; $display("FAIL to_wait%0d: got req=%b err=%b, want 1 0", i, bus_req_o, bus_err_o); end
            tick();
        end
        total++; if (bus_req_o !== 1'b0 || bus_err_o !== 1'b1 || ram_rdata_o !== 32'h0 || stallreq_o !== 1'b0) begin
            bad++; $display("FAIL to_abort: got req=%b err=%b ram=%h stall=%b, want 0 1 00000000 0",
                            bus_req_o, bus_err_o, ram_rdata_o, stallreq_o); end
        ram_ce_i = 1'b0; rom_ce_i = 1'b0;
        tick();
        total++; if (bus_req_o !== 1'b0 || bus_err_o !== 1'b0 || exp_q.size() != 1) begin
            bad++; $display("FAIL to_after: got req=%b err=%b pending=%0d, want 0 0 1", bus_req_o, bus_err_o, exp_q.size()); end
        exp_q.delete();
        mem_never = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_wait = 0;
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h600, wdata: 32'h0});
        rd_q.push_back(32'h11112222);
        rom_ce_i = 1'b1; rom_addr_i = 32'h600;
        tick(); tick();
        total++; if (rom_data_o !== 32'h11112222) begin bad++; $display("FAIL rm_pre: got %h want 11112222", rom_data_o); end
        rom_ce_i = 1'b0;
        tick();
        mem_wait = 5;
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h700, wdata: 32'h0});
        rom_ce_i = 1'b1; rom_addr_i = 32'h700;
        tick();
        total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rm_inst: got req=%b want 1", bus_req_o); end
        #2 rst = 1'b0;
        #1;
        total++; if ({bus_req_o, bus_sel_o, bus_addr_o, rom_data_o} !== '0) begin
            bad++; $display("FAIL rm_async: got req=%b sel=%h addr=%h rom=%h, want all 0", bus_req_o, bus_sel_o, bus_addr_o, rom_data_o); end
        rom_ce_i = 1'b0;
        exp_q.delete(); rd_q.delete(); wcnt = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_wait = 0;
        exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h800, wdata: 32'h0});
        rd_q.push_back(32'h0BADF00D);
        rom_ce_i = 1'b1; rom_addr_i = 32'h800;
        tick();
        total++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h800) begin
            bad++; $display("FAIL rm_refetch: got req=%b addr=%h, want 1 00000800", bus_req_o, bus_addr_o); end
        tick();
        total++; if (rom_data_o !== 32'h0BADF00D || stallreq_o !== 1'b0) begin
            bad++; $display("FAIL rm_done: got rom=%h stall=%b, want 0badf00d 0", rom_data_o, stallreq_o); end
        rom_ce_i = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        total++; if (bus_req_o !== 1'b0 || rom_data_o !== 32'h0BADF00D || ram_rdata_o !== 32'h0) begin
            bad++; $display("FAIL stray_ack: got req=%b rom=%h ram=%h, want 0 0badf00d 00000000", bus_req_o, rom_data_o, ram_rdata_o); end
    endtask

    initial begin
        rst = 1'b0; rom_ce_i = 1'b0; ram_ce_i = 1'b0; ram_we_i = 1'b0; flush_i = 1'b0; bus_ack_i = 1'b0;
        rom_addr_i = '0; ram_addr_i = '0; ram_wdata_i = '0; ram_sel_i = '0; bus_rdata_i = '0;
        test_reset();
        test_fetch();
        test_load_fetch();
        test_store_wait();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external single-port memory bus between the CPU's instruction-fetch port (pc_reg/if side) and data port (mem stage).
- Data access has priority and is served first; instruction fetch follows.
- Holds the pipeline through stallreq_o until both accesses of the current cycle finish, then presents the buffered results for one cycle.
- Includes a watchdog for a memory that never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles a bus access may wait for bus_ack_i before abort.
- CNT_W, 7: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- rom_ce_i  in  1  fetch request.
- rom_addr_i  in  32  fetch address.
- rom_data_o  out  32  fetched instruction (valid in DONE).
- ram_ce_i  in  1  data request.
- ram_we_i  in  1  1=store, 0=load.
- ram_sel_i  in  4  byte enables.
- ram_addr_i  in  32  data address.
- ram_wdata_i  in  32  store data.
- ram_rdata_o  out  32  load data (valid in DONE).
- flush_i  in  1  pipeline flush from ctrl.
- stallreq_o  out  1  stall request to ctrl.
- bus_req_o  out  1  memory request, registered.
- bus_we_o  out  1  write enable.
- bus_sel_o  out  4  byte enables (4'b1111 on fetch).
- bus_addr_o  out  32  address.
- bus_wdata_o  out  32  write data (0 on fetch and on loads).
- bus_rdata_i  in  32  read data, valid with ack.
- bus_ack_i  in  1  access complete; sampled on a rising edge while bus_req_o=1.
- bus_err_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - All bus_* outputs 0.
  - rom_data_o and ram_rdata_o 0.
  - Watchdog counter 0.
  - bus_err_o 0.
- States: IDLE, DATA, INST, DONE, DRAIN.
- stallreq_o, combinational:
  - 1 when state≠DONE and (rom_ce_i|ram_ce_i).
  - Forced 1 in DRAIN.
  - 0 when there are no requests.
- IDLE:
  - ram_ce_i=1 → DATA; bus_req_o=1 and bus_we/sel/addr/wdata are latched from ram_* on that edge.
  - Else rom_ce_i=1 → INST; bus_req_o=1, bus_we_o=0, bus_sel_o=4'hF, bus_addr_o=rom_addr_i.
  - Else stay in IDLE.
- DATA, on bus_ack_i:
  - Load: ram_rdata_o ← bus_rdata_i. Store: ram_rdata_o unchanged.
  - If rom_ce_i=1 → INST and the fetch is launched on the same edge; bus_req_o stays 1 (back-to-back).
  - Else → DONE with bus_req_o=0.
- INST, on bus_ack_i: rom_data_o ← bus_rdata_i; → DONE; bus_req_o=0.
- DONE:
  - Exactly one cycle, stallreq_o=0 so the pipeline advances and samples the buffers.
  - Next state IDLE. New requests are not accepted in DONE.
- Bus outputs stay stable while bus_req_o=1 and no ack is seen.
- Minimum latency, zero-wait memory:
  - Fetch only: 3 cycles (IDLE, INST, DONE).
  - Data plus fetch: 4 cycles.
- Flush:
  - flush_i=1 in IDLE or DONE → IDLE, no bus activity.
  - flush_i=1 in DATA or INST: the outstanding access is never withdrawn. → DRAIN; bus outputs are held until ack, then the result is discarded.
  - Any queued fetch is dropped. → IDLE.
  - flush_i and bus_ack_i in the same cycle: the ack completes the access; the result is discarded; → IDLE.
- Watchdog:
  - Counter is cleared on every state entry and increments each cycle in DATA, INST or DRAIN while no ack arrives.
  - On reaching TIMEOUT_CYCLES: bus_req_o ← 0; bus_err_o pulses 1 for one cycle; the affected result buffer ← 0.
  - Then → DONE from DATA or INST, or → IDLE from DRAIN.
  - The queued fetch after a timed-out data access is skipped.
- An ack while bus_req_o=0 is ignored.
- Mid-operation reset returns to the reset state immediately. bus_req_o drops asynchronously.

Test Plan:
- Fetch only: rom_ce=1, addr=0x100, ack 1 cycle after req with rdata=0x3C010001 → bus_addr=0x100, sel=F, stallreq high 2 cycles, rom_data_o=0x3C010001 in DONE.
- Load plus fetch together: ram_ce=1, we=0, addr=0x2000, rom addr=0x104, zero-wait acks with data 0xDEADBEEF then 0x00000000.
  - The data access goes on the bus first, immediately followed by the fetch with bus_req continuously 1.
  - In DONE: ram_rdata_o=0xDEADBEEF and rom_data_o=0.
- Store with wait states: we=1, sel=4'b0011, wdata=0x1234, ack after 5 cycles → bus outputs stable for 5 cycles; stallreq stays 1 until DONE.
- Flush during a pending fetch at cycle 2, ack at cycle 4 → state DRAIN, bus held, rom_data_o unchanged, then IDLE.
- Timeout: never ack, TIMEOUT_CYCLES=8 → bus_req drops after 8 cycles, bus_err one-cycle pulse, result 0, DONE then IDLE.
- Reset asserted while in INST with bus_req=1 → all outputs 0 immediately, state IDLE; after release a new fetch proceeds normally.
